// File: rtl/floo_mcast_rsp_join.sv
// Multicast response join: collects one response per route named in the
// expected-mask FIFO head and emits a single joined response carrying the
// first accepted flit and the worst (largest) AXI response code.
module floo_mcast_rsp_join #(
  parameter int unsigned NumRoutes      = 5,
  parameter int unsigned NumOutstanding = 4,
  parameter type         flit_t         = logic
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    mask_valid_i,
  output logic                                    mask_ready_o,
  input  logic [NumRoutes-1:0]                    mask_i,
  input  logic [NumRoutes-1:0]                    valid_i,
  output logic [NumRoutes-1:0]                    ready_o,
  input  flit_t                                   data_i [NumRoutes],
  input  logic [NumRoutes-1:0][1:0]               resp_i,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output flit_t                                   data_o,
  output logic [1:0]                              resp_o,
  output logic [$clog2(NumOutstanding+1)-1:0]     usage_o
);

  localparam int unsigned UsageW = $clog2(NumOutstanding + 1);
  localparam int unsigned PtrW   = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

  typedef logic [NumRoutes-1:0] mask_t;
  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;

  state_e            state_q, state_d;
  mask_t             mem_q [NumOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [UsageW-1:0] usage_q, usage_d;
  mask_t             head_mask, recv_q, recv_d, hs;
  logic [1:0]        acc_q, acc_d;
  flit_t             data_q, data_d;
  logic              push, pop, found;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // All-zero masks are acknowledged but never stored.
  assign mask_ready_o = (usage_q < UsageW'(NumOutstanding));
  assign push         = mask_valid_i & mask_ready_o & (|mask_i);
  assign head_mask    = mem_q[rd_ptr_q];

  // Readiness comes from state and head mask only, never from valid_i.
  assign ready_o = (state_q == COLLECT) ? (head_mask & ~recv_q) : '0;
  assign hs      = valid_i & ready_o;

  assign valid_o = (state_q == SEND);
  assign data_o  = data_q;
  assign resp_o  = acc_q;
  assign usage_o = usage_q;

  // Next-state logic and the pop strobe of the join FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:    if (push) state_d = COLLECT;
      COLLECT: if (recv_d == head_mask) state_d = SEND;
      SEND: begin
        if (ready_i) begin
          pop     = 1'b1;
          state_d = ((usage_q != UsageW'(1)) || push) ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulate received routes, worst response code and the first flit.
  always_comb begin
    recv_d = recv_q | hs;
    acc_d  = acc_q;
    data_d = data_q;
    found  = 1'b0;
    for (int unsigned r = 0; r < NumRoutes; r++) begin
      if (hs[r]) begin
        if (resp_i[r] > acc_d) acc_d = resp_i[r];
        if ((recv_q == '0) && !found) data_d = data_i[r];
        found = 1'b1;
      end
    end
    if (pop) begin
      recv_d = '0;
      acc_d  = '0;
    end
  end

  // FIFO occupancy bookkeeping.
  always_comb begin
    unique case ({push, pop})
      2'b10:   usage_d = usage_q + UsageW'(1);
      2'b01:   usage_d = usage_q - UsageW'(1);
      default: usage_d = usage_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and FIFO pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      recv_q   <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      usage_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      recv_q  <= recv_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      usage_q <= usage_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Mask storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage array has no reset; entries are only read after being written, usage_q alone defines emptiness.
    if (push) mem_q[wr_ptr_q] <= mask_i;
  end

endmodule

// File: tb/tb_floo_mcast_rsp_join.sv
// Self-checking bench for floo_mcast_rsp_join: a transaction-level model
// (queue of expected masks plus a join accumulator) checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_floo_mcast_rsp_join;

  localparam int NR = 5;
  localparam int NO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            mask_valid_i, mask_ready_o;
  logic [NR-1:0]   mask_i, valid_i, ready_o;
  logic [7:0]      data_i [NR];
  logic [NR-1:0][1:0] resp_i;
  logic            valid_o, ready_i;
  logic [7:0]      data_o;
  logic [1:0]      resp_o;
  logic [2:0]      usage_o;

  int checks   = 0;
  int failures = 0;

  floo_mcast_rsp_join #(
    .NumRoutes(NR), .NumOutstanding(NO), .flit_t(logic [7:0])
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mask_valid_i(mask_valid_i), .mask_ready_o(mask_ready_o), .mask_i(mask_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .resp_i(resp_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .resp_o(resp_o),
    .usage_o(usage_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NR-1:0] mq [$];
  logic [NR-1:0] m_got   = '0;
  int            m_acc   = 0;
  bit            m_have  = 0;
  logic [7:0]    m_first = '0;
  bit            m_out_v = 0;
  logic [7:0]    m_out_d = '0;
  logic [1:0]    m_out_r = '0;

  function automatic logic [NR-1:0] m_ready();
    if (m_out_v || mq.size() == 0) return '0;
    return mq[0] & ~m_got;
  endfunction

  task automatic model_step();
    logic [NR-1:0] hs;
    bit push, pop;
    if (rst_i) begin
      mq.delete();
      m_got = '0; m_acc = 0; m_have = 0; m_out_v = 0;
      return;
    end
    hs   = valid_i & m_ready();
    push = mask_valid_i && (mq.size() < NO) && (mask_i != '0);
    pop  = m_out_v && ready_i;
    for (int r = 0; r < NR; r++) begin
      if (hs[r]) begin
        if (!m_have) begin m_first = data_i[r]; m_have = 1; end
        if (int'(resp_i[r]) > m_acc) m_acc = int'(resp_i[r]);
      end
    end
    m_got = m_got | hs;
    if (pop) begin
      mq.delete(0);
      m_out_v = 0; m_got = '0; m_acc = 0; m_have = 0;
    end else if (!m_out_v && mq.size() > 0 && m_got == mq[0]) begin
      m_out_v = 1;
      m_out_d = m_first;
      m_out_r = 2'(m_acc);
    end
    if (push) mq.push_back(mask_i);
  endtask

  always @(posedge clk_i or posedge rst_i) model_step();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    check("m_ready_o", 32'(ready_o), 32'(m_ready()));
    check("m_valid_o", 32'(valid_o), 32'(m_out_v));
    check("m_usage_o", 32'(usage_o), mq.size());
    check("m_mask_ready_o", 32'(mask_ready_o), 32'(mq.size() < NO));
    if (m_out_v) begin
      check("m_data_o", 32'(data_o), 32'(m_out_d));
      check("m_resp_o", 32'(resp_o), 32'(m_out_r));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_mask(input logic [NR-1:0] m);
    mask_valid_i = 1'b1;
    mask_i       = m;
    tick();
    mask_valid_i = 1'b0;
    mask_i       = '0;
  endtask

  initial begin
    mask_valid_i = 1'b0; mask_i = '0; valid_i = '0; ready_i = 1'b0; resp_i = '0;
    for (int r = 0; r < NR; r++) data_i[r] = 8'hA0 + 8'(r);
    repeat (2) tick();

    // Reset state.
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd0);
    check("rst_usage_o", 32'(usage_o), 32'd0);
    check("rst_mask_ready_o", 32'(mask_ready_o), 32'd1);
    check("rst_resp_o", 32'(resp_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Zero mask is swallowed.
    push_mask(5'b00000);
    check("zero_usage", 32'(usage_o), 32'd0);
    tick();
    check("zero_valid_o", 32'(valid_o), 32'd0);
    check("zero_ready_o", 32'(ready_o), 32'd0);

    // Mask 00110, staggered responses, unexpected route 0 also valid.
    push_mask(5'b00110);
    check("j1_ready_start", 32'(ready_o), 32'b00110);
    valid_i = 5'b00011; resp_i[1] = 2'd0; resp_i[0] = 2'd3;
    tick();
    valid_i = '0;
    check("j1_ready_mid", 32'(ready_o), 32'b00100);
    tick();
    check("j1_valid_early", 32'(valid_o), 32'd0);
    valid_i = 5'b00101; resp_i[2] = 2'd2;
    tick();
    valid_i = '0;
    check("j1_valid_o", 32'(valid_o), 32'd1);
    check("j1_resp_o", 32'(resp_o), 32'd2);
    check("j1_data_o", 32'(data_o), 32'hA1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0; resp_i = '0;
    check("j1_done_valid", 32'(valid_o), 32'd0);
    check("j1_done_usage", 32'(usage_o), 32'd0);

    // All five routes in one cycle, then back-pressure for three cycles.
    push_mask(5'b11111);
    resp_i[0] = 2'd2; resp_i[1] = 2'd0; resp_i[2] = 2'd3; resp_i[3] = 2'd1; resp_i[4] = 2'd0;
    valid_i = 5'b11111;
    check("j2_ready_all", 32'(ready_o), 32'b11111);
    tick();
    data_i[0] = 8'h55;
    check("j2_valid_o", 32'(valid_o), 32'd1);
    check("j2_resp_o", 32'(resp_o), 32'd3);
    check("j2_data_o", 32'(data_o), 32'hA0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_valid_o", 32'(valid_o), 32'd1);
      check("hold_resp_o", 32'(resp_o), 32'd3);
      check("hold_data_o", 32'(data_o), 32'hA0);
      check("hold_ready_o", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1; valid_i = '0; data_i[0] = 8'hA0;
    tick();
    ready_i = 1'b0; resp_i = '0;
    check("j2_done_valid", 32'(valid_o), 32'd0);
    check("j2_done_usage", 32'(usage_o), 32'd0);

    // Fill the FIFO; fifth push held until after the first pop.
    push_mask(5'b00001);
    push_mask(5'b00010);
    push_mask(5'b00100);
    push_mask(5'b01000);
    check("full_usage", 32'(usage_o), 32'd4);
    check("full_mask_ready", 32'(mask_ready_o), 32'd0);
    mask_valid_i = 1'b1; mask_i = 5'b10000;
    tick();
    check("full_held", 32'(usage_o), 32'd4);
    valid_i = 5'b00001; resp_i[0] = 2'd1;
    tick();
    valid_i = '0;
    check("full_join_valid", 32'(valid_o), 32'd1);
    check("full_join_data", 32'(data_o), 32'hA0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("full_pop_usage", 32'(usage_o), 32'd3);
    check("full_pop_mready", 32'(mask_ready_o), 32'd1);
    tick();
    mask_valid_i = 1'b0; mask_i = '0;
    check("full_fifth_pushed", 32'(usage_o), 32'd4);
    resp_i = '0;
    for (int i = 1; i < NR; i++) begin
      valid_i = NR'(1 << i);
      resp_i[i] = 2'(i % 4);
      tick();
      valid_i = '0;
      check("drain_valid_o", 32'(valid_o), 32'd1);
      check("drain_data_o", 32'(data_o), 32'(8'hA0 + 8'(i)));
      check("drain_resp_o", 32'(resp_o), 32'(i % 4));
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
    end
    resp_i = '0;
    check("drain_usage", 32'(usage_o), 32'd0);

    // Reset in the middle of a collection.
    push_mask(5'b00111);
    valid_i = 5'b00001; resp_i[0] = 2'd2;
    tick();
    valid_i = '0;
    check("mid_ready_o", 32'(ready_o), 32'b00110);
    rst_i = 1'b1;
    #1;
    check("arst_valid_o", 32'(valid_o), 32'd0);
    check("arst_usage_o", 32'(usage_o), 32'd0);
    check("arst_ready_o", 32'(ready_o), 32'd0);
    check("arst_mask_ready", 32'(mask_ready_o), 32'd1);
    check("arst_resp_o", 32'(resp_o), 32'd0);
    tick();
    rst_i = 1'b0; resp_i = '0;
    tick();
    push_mask(5'b00101);
    resp_i[0] = 2'd1; resp_i[2] = 2'd0;
    valid_i = 5'b00101;
    tick();
    valid_i = '0;
    check("post_rst_valid", 32'(valid_o), 32'd1);
    check("post_rst_resp", 32'(resp_o), 32'd1);
    check("post_rst_data", 32'(data_o), 32'hA0);

    // Push in the same cycle as a pop.
    ready_i = 1'b1; mask_valid_i = 1'b1; mask_i = 5'b01000;
    tick();
    ready_i = 1'b0; mask_valid_i = 1'b0; mask_i = '0;
    check("pushpop_usage", 32'(usage_o), 32'd1);
    check("pushpop_ready", 32'(ready_o), 32'b01000);
    check("pushpop_valid", 32'(valid_o), 32'd0);
    valid_i = 5'b01000; resp_i = '0; resp_i[3] = 2'd3;
    tick();
    valid_i = '0;
    check("pushpop_join_valid", 32'(valid_o), 32'd1);
    check("pushpop_join_resp", 32'(resp_o), 32'd3);
    check("pushpop_join_data", 32'(data_o), 32'hA3);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0; resp_i = '0;
    check("final_usage", 32'(usage_o), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
